// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal direction predictor with a direct-mapped tagged BTB for RV32I fetch.
// Lookups return a registered prediction one cycle later; ROB commits train the tables.
module branch_predictor_gshare #(
    parameter int unsigned PHT_ENTRIES = 256,
    parameter int unsigned BTB_ENTRIES = 64,
    parameter int unsigned GHR_BITS    = 8,
    parameter int unsigned TAG_BITS    = 10,
    parameter int unsigned GSHARE      = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        lookup_valid_in,
    input  logic [31:0] lookup_pc_in,
    output logic        pred_valid_out,
    output logic        pred_taken_out,
    output logic [31:0] pred_target_out,
    output logic        pred_btb_hit_out,
    input  logic        upd_valid_in,
    input  logic        upd_is_cond_in,
    input  logic [31:0] upd_pc_in,
    input  logic        upd_taken_in,
    input  logic [31:0] upd_target_in
);

    localparam int unsigned PhtIdxW = $clog2(PHT_ENTRIES);
    localparam int unsigned BtbIdxW = $clog2(BTB_ENTRIES);

    logic [1:0]          pht_q        [PHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_BITS-1:0] btb_tag_q    [BTB_ENTRIES];
    logic [31:0]         btb_target_q [BTB_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_uncond_q;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    logic                pred_valid_q, pred_taken_q, pred_hit_q;
    logic [31:0]         pred_target_q;

    logic [PhtIdxW-1:0]  lk_pidx, up_pidx;
    logic [BtbIdxW-1:0]  lk_bidx, up_bidx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic                lk_hit, lk_taken;
    logic [31:0]         lk_target;
    logic [1:0]          ctr_cur, ctr_d;
    logic                unused_upd_pc;

    assign unused_upd_pc = ^upd_pc_in;

    always_comb begin
        lk_pidx = lookup_pc_in[2 +: PhtIdxW];
        up_pidx = upd_pc_in[2 +: PhtIdxW];
        if (GSHARE != 0) begin
            lk_pidx = lk_pidx ^ PhtIdxW'(ghr_q);
            up_pidx = up_pidx ^ PhtIdxW'(ghr_q);
        end
        lk_bidx = lookup_pc_in[2 +: BtbIdxW];
        lk_tag  = lookup_pc_in[2 + BtbIdxW +: TAG_BITS];
        up_bidx = upd_pc_in[2 +: BtbIdxW];
        up_tag  = upd_pc_in[2 + BtbIdxW +: TAG_BITS];
    end

    always_comb begin
        lk_hit    = btb_valid_q[lk_bidx] && (btb_tag_q[lk_bidx] == lk_tag);
        lk_taken  = lk_hit && (btb_uncond_q[lk_bidx] || pht_q[lk_pidx][1]);
        lk_target = lk_taken ? btb_target_q[lk_bidx] : lookup_pc_in + 32'd4;
    end

    always_comb begin
        ctr_cur = pht_q[up_pidx];
        if (upd_taken_in) begin
            ctr_d = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
        end else begin
            ctr_d = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
        end
        // Shift works for GHR_BITS == 1 too: the shifted-out bit simply vanishes.
        ghr_d = (ghr_q << 1) | GHR_BITS'(upd_taken_in);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pht_q        <= '{default: 2'b01};
            btb_valid_q  <= '0;
            btb_uncond_q <= '0;
            ghr_q        <= '0;
        end else if (rdy_in && upd_valid_in) begin
            if (upd_is_cond_in) begin
                pht_q[up_pidx] <= ctr_d;
                ghr_q          <= ghr_d;
            end
            if (upd_taken_in) begin
                btb_valid_q[up_bidx]  <= 1'b1;
                btb_uncond_q[up_bidx] <= !upd_is_cond_in;
            end
        end
    end

    // Tag/target payload is qualified by btb_valid_q, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && upd_valid_in && upd_taken_in) begin
            btb_tag_q[up_bidx]    <= up_tag;
            btb_target_q[up_bidx] <= upd_target_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_target_q <= '0;
        end else if (rdy_in) begin
            pred_valid_q <= lookup_valid_in;
            if (lookup_valid_in) begin
                pred_taken_q  <= lk_taken;
                pred_hit_q    <= lk_hit;
                pred_target_q <= lk_target;
            end
        end
    end

    assign pred_valid_out   = pred_valid_q;
    assign pred_taken_out   = pred_taken_q;
    assign pred_target_out  = pred_target_q;
    assign pred_btb_hit_out = pred_hit_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: a bimodal instance driven from a vector table, plus a gshare instance
// and hand-written sequences for rdy hold, mid-stream reset and history indexing.
module tb_branch_predictor_gshare;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        lookup_valid_in, upd_valid_in, upd_is_cond_in, upd_taken_in;
    logic [31:0] lookup_pc_in, upd_pc_in, upd_target_in;
    logic        pred_valid_out, pred_taken_out, pred_btb_hit_out;
    logic [31:0] pred_target_out;

    logic        g_lookup_valid, g_upd_valid, g_upd_is_cond, g_upd_taken;
    logic [31:0] g_lookup_pc, g_upd_pc, g_upd_target;
    logic        g_pred_valid, g_pred_taken, g_pred_hit;
    logic [31:0] g_pred_target;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    branch_predictor_gshare #(.GSHARE(0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .lookup_valid_in(lookup_valid_in), .lookup_pc_in(lookup_pc_in),
        .pred_valid_out(pred_valid_out), .pred_taken_out(pred_taken_out),
        .pred_target_out(pred_target_out), .pred_btb_hit_out(pred_btb_hit_out),
        .upd_valid_in(upd_valid_in), .upd_is_cond_in(upd_is_cond_in),
        .upd_pc_in(upd_pc_in), .upd_taken_in(upd_taken_in), .upd_target_in(upd_target_in)
    );

    branch_predictor_gshare #(.GSHARE(1)) dut_g (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .lookup_valid_in(g_lookup_valid), .lookup_pc_in(g_lookup_pc),
        .pred_valid_out(g_pred_valid), .pred_taken_out(g_pred_taken),
        .pred_target_out(g_pred_target), .pred_btb_hit_out(g_pred_hit),
        .upd_valid_in(g_upd_valid), .upd_is_cond_in(g_upd_is_cond),
        .upd_pc_in(g_upd_pc), .upd_taken_in(g_upd_taken), .upd_target_in(g_upd_target)
    );

    typedef struct {
        logic        uv;
        logic        uc;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        lv;
        logic [31:0] lpc;
        logic        eh;
        logic        etk;
        logic [31:0] etg;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t row(input logic uv, input logic uc, input logic [31:0] upc,
                                 input logic ut, input logic [31:0] utg, input logic lv,
                                 input logic [31:0] lpc, input logic eh, input logic etk,
                                 input logic [31:0] etg);
        vec_t v;
        v.uv = uv; v.uc = uc; v.upc = upc; v.ut = ut; v.utg = utg;
        v.lv = lv; v.lpc = lpc; v.eh = eh; v.etk = etk; v.etg = etg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        upd_valid_in    = v.uv;
        upd_is_cond_in  = v.uc;
        upd_pc_in       = v.upc;
        upd_taken_in    = v.ut;
        upd_target_in   = v.utg;
        lookup_valid_in = v.lv;
        lookup_pc_in    = v.lpc;
    endtask

    task automatic apply_and_check(input string tag, input vec_t v);
        drive(v);
        @(posedge clk_in);
        #1;
        chk({tag, " valid"}, 32'(pred_valid_out), 32'(v.lv));
        if (v.lv) begin
            chk({tag, " hit"}, 32'(pred_btb_hit_out), 32'(v.eh));
            chk({tag, " taken"}, 32'(pred_taken_out), 32'(v.etk));
            chk({tag, " target"}, pred_target_out, v.etg);
        end
    endtask

    task automatic g_step(input logic uv, input logic [31:0] upc, input logic ut,
                          input logic [31:0] utg, input logic lv, input logic [31:0] lpc);
        g_upd_valid    = uv;
        g_upd_is_cond  = 1'b1;
        g_upd_pc       = upc;
        g_upd_taken    = ut;
        g_upd_target   = utg;
        g_lookup_valid = lv;
        g_lookup_pc    = lpc;
        @(posedge clk_in);
        #1;
    endtask

    localparam vec_t Idle = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};

    initial begin
        vecs[0]  = row(0, 0, 0,      0, 0,      1, 32'h100, 0, 0, 32'h104);
        vecs[1]  = row(0, 0, 0,      0, 0,      0, 0,       0, 0, 0);
        vecs[2]  = row(1, 1, 32'h100, 1, 32'h80, 0, 0,       0, 0, 0);
        vecs[3]  = row(1, 1, 32'h100, 1, 32'h80, 0, 0,       0, 0, 0);
        vecs[4]  = row(0, 0, 0,      0, 0,      1, 32'h100, 1, 1, 32'h80);
        vecs[5]  = row(1, 1, 32'h100, 0, 0,      1, 32'h100, 1, 1, 32'h80);
        vecs[6]  = row(1, 1, 32'h100, 0, 0,      0, 0,       0, 0, 0);
        vecs[7]  = row(1, 1, 32'h100, 0, 0,      0, 0,       0, 0, 0);
        vecs[8]  = row(0, 0, 0,      0, 0,      1, 32'h100, 1, 0, 32'h104);
        vecs[9]  = row(1, 1, 32'h100, 0, 0,      0, 0,       0, 0, 0);
        vecs[10] = row(1, 1, 32'h100, 1, 32'h80, 0, 0,       0, 0, 0);
        vecs[11] = row(0, 0, 0,      0, 0,      1, 32'h100, 1, 0, 32'h104);
        vecs[12] = row(1, 1, 32'h100, 1, 32'h80, 0, 0,       0, 0, 0);
        vecs[13] = row(0, 0, 0,      0, 0,      1, 32'h100, 1, 1, 32'h80);
        vecs[14] = row(1, 0, 32'h200, 1, 32'h400, 0, 0,      0, 0, 0);
        vecs[15] = row(0, 0, 0,      0, 0,      1, 32'h200, 1, 1, 32'h400);
        vecs[16] = row(0, 0, 0,      0, 0,      1, 32'h100, 0, 0, 32'h104);
        vecs[17] = row(1, 1, 32'h100, 1, 32'h80, 0, 0,       0, 0, 0);
        vecs[18] = row(0, 0, 0,      0, 0,      1, 32'h200, 0, 0, 32'h204);
        vecs[19] = row(0, 0, 0,      0, 0,      1, 32'h100, 1, 1, 32'h80);
        vecs[20] = row(1, 1, 32'h300, 1, 32'h380, 1, 32'h300, 0, 0, 32'h304);
        vecs[21] = row(0, 0, 0,      0, 0,      1, 32'h300, 1, 1, 32'h380);
        vecs[22] = row(0, 0, 0,      0, 0,      1, 32'hFFFF_FFFC, 0, 0, 32'h0);
        vecs[23] = row(0, 0, 0,      0, 0,      0, 0,       0, 0, 0);

        rst_in = 1'b0;
        rdy_in = 1'b1;
        drive(Idle);
        g_lookup_valid = 1'b0; g_lookup_pc = '0; g_upd_valid = 1'b0;
        g_upd_is_cond = 1'b0; g_upd_pc = '0; g_upd_taken = 1'b0; g_upd_target = '0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset valid", 32'(pred_valid_out), 32'd0);
        chk("reset taken", 32'(pred_taken_out), 32'd0);
        chk("reset hit", 32'(pred_btb_hit_out), 32'd0);
        chk("reset target", pred_target_out, 32'd0);
        rst_in = 1'b1;

        for (int i = 0; i < 24; i++) begin
            apply_and_check($sformatf("row%0d", i), vecs[i]);
        end

        // rdy low: outputs and tables freeze while inputs keep changing.
        apply_and_check("pre_rdy", row(0, 0, 0, 0, 0, 1, 32'h300, 1, 1, 32'h380));
        rdy_in = 1'b0;
        drive(row(1, 1, 32'h300, 0, 0, 1, 32'h100, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_in);
            #1;
            chk($sformatf("rdy_hold%0d valid", c), 32'(pred_valid_out), 32'd1);
            chk($sformatf("rdy_hold%0d taken", c), 32'(pred_taken_out), 32'd1);
            chk($sformatf("rdy_hold%0d hit", c), 32'(pred_btb_hit_out), 32'd1);
            chk($sformatf("rdy_hold%0d target", c), pred_target_out, 32'h380);
        end
        rdy_in = 1'b1;
        apply_and_check("post_rdy_idle", Idle);
        apply_and_check("post_rdy", row(0, 0, 0, 0, 0, 1, 32'h300, 1, 1, 32'h380));

        // Asynchronous reset in the middle of a cycle clears outputs without a clock edge.
        apply_and_check("pre_rst", row(0, 0, 0, 0, 0, 1, 32'h300, 1, 1, 32'h380));
        #2;
        rst_in = 1'b0;
        #1;
        chk("midrst valid", 32'(pred_valid_out), 32'd0);
        chk("midrst taken", 32'(pred_taken_out), 32'd0);
        chk("midrst hit", 32'(pred_btb_hit_out), 32'd0);
        chk("midrst target", pred_target_out, 32'd0);
        drive(Idle);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        apply_and_check("post_rst", row(0, 0, 0, 0, 0, 1, 32'h300, 0, 0, 32'h304));

        // Gshare: commits T,N,T leave GHR = 3'b101, moving each pc to a new PHT entry.
        g_step(1, 32'h104, 1, 32'h80, 0, 0);
        g_step(1, 32'h108, 0, 0,      0, 0);
        g_step(1, 32'h110, 1, 32'h90, 0, 0);
        g_step(0, 0, 0, 0, 1, 32'h110);
        chk("gs 0x110 valid", 32'(g_pred_valid), 32'd1);
        chk("gs 0x110 hit", 32'(g_pred_hit), 32'd1);
        chk("gs 0x110 taken", 32'(g_pred_taken), 32'd1);
        chk("gs 0x110 target", g_pred_target, 32'h90);
        g_step(0, 0, 0, 0, 1, 32'h104);
        chk("gs 0x104 valid", 32'(g_pred_valid), 32'd1);
        chk("gs 0x104 hit", 32'(g_pred_hit), 32'd1);
        chk("gs 0x104 taken", 32'(g_pred_taken), 32'd0);
        chk("gs 0x104 target", g_pred_target, 32'h108);
        g_step(0, 0, 0, 0, 0, 0);
        chk("gs idle valid", 32'(g_pred_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
